id_ex_stage: RTL and testbench

// - ID/EX pipeline register that directly feeds ALU operands (src1, src2) and ALUType.
// - Captures decoded ops, resolves operands with EX/MEM and MEM/WB forwarding and an imm select.
// - Single-entry valid/ready buffer with stall, flush and snoop of writes while holding.

---
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with forwarding, imm select and stall snooping (optional STALL_CNT_EN stall counter)
module id_ex_stage #(
  parameter int DataSize    = 32,
  parameter int ALUopSize   = 4,
  parameter int RegAddrSize = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RegAddrSize-1:0] in_rs1_addr,
  input  logic [RegAddrSize-1:0] in_rs2_addr,
  input  logic [DataSize-1:0]    in_rs1_data,
  input  logic [DataSize-1:0]    in_rs2_data,
  input  logic [DataSize-1:0]    in_imm,
  input  logic                   in_use_imm,
  input  logic [ALUopSize-1:0]   in_alu_type,
  input  logic [RegAddrSize-1:0] in_rd_addr,
  input  logic                   in_rd_we,
  input  logic                   flush,
  input  logic                   exmem_we,
  input  logic [RegAddrSize-1:0] exmem_rd,
  input  logic [DataSize-1:0]    exmem_data,
  input  logic                   memwb_we,
  input  logic [RegAddrSize-1:0] memwb_rd,
  input  logic [DataSize-1:0]    memwb_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DataSize-1:0]    src1,
  output logic [DataSize-1:0]    src2,
  output logic [ALUopSize-1:0]   ALUType,
  output logic [RegAddrSize-1:0] out_rd_addr,
  output logic                   out_rd_we
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);
  logic [RegAddrSize-1:0] rs1_q, rs2_q;
  logic                   use_imm_q, rd_we_q, accept, hold;
  logic [DataSize-1:0]    cap1, cap2, snp1, snp2;

  function automatic logic [DataSize-1:0] fwd(input logic [RegAddrSize-1:0] s, input logic [DataSize-1:0] d);
    return (s == '0) ? d :
           (exmem_we && exmem_rd == s) ? exmem_data :
           (memwb_we && memwb_rd == s) ? memwb_data : d;
  endfunction

  assign in_ready  = !rst && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign hold      = out_valid && !out_ready;
  assign out_rd_we = rd_we_q && out_valid;

  // operand resolution for a fresh capture and for snooping the held op
  always_comb begin
    cap1 = fwd(in_rs1_addr, in_rs1_data);
    cap2 = in_use_imm ? in_imm : fwd(in_rs2_addr, in_rs2_data);
    snp1 = fwd(rs1_q, src1);
    snp2 = use_imm_q ? src2 : fwd(rs2_q, src2);
  end

  // pipeline register: flush beats accept, accept beats snoop
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      src1        <= '0;
      src2        <= '0;
      ALUType     <= '0;
      out_rd_addr <= '0;
      rd_we_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rd_we_q   <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      src1        <= cap1;
      src2        <= cap2;
      ALUType     <= in_alu_type;
      out_rd_addr <= in_rd_addr;
      rd_we_q     <= in_rd_we;
      rs1_q       <= in_rs1_addr;
      rs2_q       <= in_rs2_addr;
      use_imm_q   <= in_use_imm;
    end else if (hold) begin
      src1 <= snp1;
      src2 <= snp2;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef STALL_CNT_EN
  // saturating count of cycles the held op waits on the ALU side
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (hold && stall_cnt != 32'hffffffff) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, hand sequences and randomized model check for id_ex_stage
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_use_imm, in_rd_we, flush;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, exmem_rd, memwb_rd, out_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, exmem_data, memwb_data, src1, src2;
  logic [3:0]  in_alu_type, ALUType;
  logic        exmem_we, memwb_we, out_ready, out_valid, out_rd_we;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_type(in_alu_type),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .flush(flush),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_ready(out_ready), .out_valid(out_valid), .src1(src1), .src2(src2),
    .ALUType(ALUType), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  r1, r2;
    logic [31:0] d1, d2, imm;
    logic        ui;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        we, ew;
    logic [4:0]  er;
    logic [31:0] ed;
    logic        mw;
    logic [4:0]  mr;
    logic [31:0] md, e1, e2;
  } vec_t;
  vec_t tv[7];

  logic        mv, mwe, mui;
  logic [31:0] ms1, ms2;
  logic [3:0]  malu;
  logic [4:0]  mrd, mr1, mr2;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_use_imm = 0; in_alu_type = 0; in_rd_addr = 0; in_rd_we = 0; flush = 0;
    exmem_we = 0; exmem_rd = 0; exmem_data = 0; memwb_we = 0; memwb_rd = 0; memwb_data = 0;
    out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2,
                    input logic [31:0] imm, input logic ui, input logic [3:0] alu, input logic [4:0] rd);
    in_valid = 1; in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = ui; in_alu_type = alu; in_rd_addr = rd; in_rd_we = 1;
  endtask

  // forwarding as an ordered list of producers, youngest first
  function automatic logic [31:0] pick(input logic [4:0] s, input logic [31:0] d);
    logic        hit[2];
    logic [31:0] val[2];
    hit[0] = exmem_we && exmem_rd == s; val[0] = exmem_data;
    hit[1] = memwb_we && memwb_rd == s; val[1] = memwb_data;
    if (s == 0) return d;
    for (int k = 0; k < 2; k++) if (hit[k]) return val[k];
    return d;
  endfunction

  initial begin
    tv[0] = '{5'd3, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, 4'd0, 5'd6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7};
    tv[1] = '{5'd3, 5'd4, 32'd1, 32'd2, 32'd0, 1'b0, 4'd1, 5'd7, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'd2};
    tv[2] = '{5'd3, 5'd5, 32'd11, 32'd12, 32'd0, 1'b0, 4'd2, 5'd1, 1'b0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 32'd11, 32'd12};
    tv[3] = '{5'd8, 5'd9, 32'd1, 32'd2, 32'd0, 1'b0, 4'd4, 5'd2, 1'b1, 1'b1, 5'd8, 32'hC0FFEE, 1'b1, 5'd9, 32'h1234, 32'hC0FFEE, 32'h1234};
    tv[4] = '{5'd9, 5'd9, 32'd3, 32'd4, 32'hFFFFFFF0, 1'b1, 4'd0, 5'd3, 1'b1, 1'b1, 5'd9, 32'h42, 1'b0, 5'd0, 32'd0, 32'h42, 32'hFFFFFFF0};
    tv[5] = '{5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd7, 5'd4, 1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'd0, 32'd0};
    tv[6] = '{5'd10, 5'd11, 32'd1, 32'd2, 32'd0, 1'b0, 4'd5, 5'd8, 1'b1, 1'b0, 5'd10, 32'd5, 1'b1, 5'd10, 32'd6, 32'd6, 32'd2};

    idle();
    rst = 1;
    tick();
    tick();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst src1", src1, 0);
    chk("rst src2", src2, 0);
    chk("rst ALUType", 32'(ALUType), 0);
    chk("rst rd_addr", 32'(out_rd_addr), 0);
    chk("rst rd_we", 32'(out_rd_we), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    rst = 0;
    #1 chk("release in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      op(tv[i].r1, tv[i].d1, tv[i].r2, tv[i].d2, tv[i].imm, tv[i].ui, tv[i].alu, tv[i].rd);
      in_rd_we = tv[i].we;
      exmem_we = tv[i].ew; exmem_rd = tv[i].er; exmem_data = tv[i].ed;
      memwb_we = tv[i].mw; memwb_rd = tv[i].mr; memwb_data = tv[i].md;
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d src1", i), src1, tv[i].e1);
      chk($sformatf("v%0d src2", i), src2, tv[i].e2);
      chk($sformatf("v%0d ALUType", i), 32'(ALUType), 32'(tv[i].alu));
      chk($sformatf("v%0d rd_addr", i), 32'(out_rd_addr), 32'(tv[i].rd));
      chk($sformatf("v%0d rd_we", i), 32'(out_rd_we), 32'(tv[i].we));
      idle();
      tick();
      chk($sformatf("v%0d consumed", i), 32'(out_valid), 0);
      chk($sformatf("v%0d src1 kept", i), src1, tv[i].e1);
    end

    op(5'd2, 32'd3, 5'd9, 32'd1, 32'd0, 1'b0, 4'd3, 5'd5);
    out_ready = 0;
    tick();
    chk("hold src2 stale", src2, 1);
    in_valid = 0;
    memwb_we = 1; memwb_rd = 9; memwb_data = 32'h55;
    tick();
    chk("snoop src2", src2, 32'h55);
    chk("snoop src1 untouched", src1, 3);
    chk("snoop out_valid", 32'(out_valid), 1);
    exmem_we = 1; exmem_rd = 2; exmem_data = 32'hA1; memwb_rd = 2; memwb_data = 32'hB2;
    tick();
    chk("snoop src1 exmem wins", src1, 32'hA1);
    chk("snoop src2 kept", src2, 32'h55);

    idle();
    op(5'd0, 32'd0, 5'd9, 32'd8, 32'h77, 1'b1, 4'd6, 5'd1);
    #1 chk("b2b in_ready", 32'(in_ready), 1);
    tick();
    chk("b2b out_valid", 32'(out_valid), 1);
    chk("b2b src2 imm", src2, 32'h77);
    chk("b2b ALUType", 32'(ALUType), 6);
    in_valid = 0; out_ready = 0;
    memwb_we = 1; memwb_rd = 9; memwb_data = 32'h55;
    tick();
    chk("imm blocks snoop", src2, 32'h77);

    memwb_we = 0;
    op(5'd1, 32'h999, 5'd1, 32'h999, 32'd0, 1'b0, 4'd1, 5'd2);
    flush = 1;
    #1 chk("flush in_ready", 32'(in_ready), 0);
    tick();
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush rd_we", 32'(out_rd_we), 0);
    chk("flush no load", 32'(ALUType), 6);

    idle();
    out_ready = 0;
    op(5'd1, 32'h31, 5'd2, 32'h32, 32'd0, 1'b0, 4'd5, 5'd9);
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    chk("rst stall out_valid", 32'(out_valid), 0);
    chk("rst stall src1", src1, 0);
    chk("rst stall ALUType", 32'(ALUType), 0);
    chk("rst stall rd_addr", 32'(out_rd_addr), 0);
    rst = 0;
    idle();

    {mv, mwe, mui, ms1, ms2, malu, mrd, mr1, mr2} = '0;
    for (int c = 0; c < 500; c++) begin
      logic        exp_rdy, nv, nwe, nui;
      logic [31:0] n1, n2;
      logic [3:0]  nalu;
      logic [4:0]  nrd, nr1, nr2;
      rst = ($urandom % 40) == 0;
      in_valid = ($urandom % 4) != 0;
      in_rs1_addr = 5'($urandom % 4); in_rs2_addr = 5'($urandom % 4);
      in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_use_imm = ($urandom % 4) == 0; in_alu_type = 4'($urandom % 8);
      in_rd_addr = 5'($urandom); in_rd_we = 1'($urandom);
      flush = ($urandom % 10) == 0; out_ready = ($urandom % 3) != 0;
      exmem_we = 1'($urandom); exmem_rd = 5'($urandom % 4); exmem_data = $urandom;
      memwb_we = 1'($urandom); memwb_rd = 5'($urandom % 4); memwb_data = $urandom;
      #1;
      exp_rdy = !rst && !flush && (!mv || out_ready);
      chk("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
      {nv, nwe, nui, n1, n2, nalu, nrd, nr1, nr2} = {mv, mwe, mui, ms1, ms2, malu, mrd, mr1, mr2};
      if (rst) {nv, nwe, nui, n1, n2, nalu, nrd, nr1, nr2} = '0;
      else if (flush) begin
        nv = 0; nwe = 0;
      end else if (in_valid && exp_rdy) begin
        nv = 1; nwe = in_rd_we; nui = in_use_imm; nalu = in_alu_type; nrd = in_rd_addr;
        nr1 = in_rs1_addr; nr2 = in_rs2_addr;
        n1 = pick(in_rs1_addr, in_rs1_data);
        n2 = in_use_imm ? in_imm : pick(in_rs2_addr, in_rs2_data);
      end else if (mv && !out_ready) begin
        n1 = pick(mr1, ms1);
        if (!mui) n2 = pick(mr2, ms2);
      end else nv = 0;
      tick();
      {mv, mwe, mui, ms1, ms2, malu, mrd, mr1, mr2} = {nv, nwe, nui, n1, n2, nalu, nrd, nr1, nr2};
      chk("rnd out_valid", 32'(out_valid), 32'(mv));
      chk("rnd src1", src1, ms1);
      chk("rnd src2", src2, ms2);
      chk("rnd ALUType", 32'(ALUType), 32'(malu));
      chk("rnd rd_addr", 32'(out_rd_addr), 32'(mrd));
      chk("rnd rd_we", 32'(out_rd_we), 32'(mwe && mv));
    end

`ifdef STALL_CNT_EN
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("stall_cnt reset", stall_cnt, 0);
    out_ready = 0;
    op(5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 4'd0, 5'd3);
    tick();
    in_valid = 0;
    repeat (4) tick();
    out_ready = 1;
    tick();
    chk("stall_cnt 4", stall_cnt, 4);
    rst = 1;
    tick();
    chk("stall_cnt cleared", stall_cnt, 0);
    rst = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
